// File: rtl/tconv_seq_ctrl.sv
// Convolution / transposed-convolution pass sequencer.
// Walks (filter, channel) passes: weight load, IFM raster sweep with a one-cycle
// gap between lines, then a pass-advance cycle. All datapath strobes are decoded
// from the registered state and counters, qualified only by the ready input.
module tconv_seq_ctrl #(
    parameter int K      = 4,
    parameter int IFM    = 9,
    parameter int STRIDE = 2,
    parameter int PAD    = 2,
    parameter int CI     = 3,
    parameter int CO     = 4,
    parameter int CW     = 10
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_mode,
    input  logic             ready,
    output logic             busy,
    output logic             done,
    output logic             wgt_rd,
    output logic [K*K-1:0]   wgt_sel,
    output logic             ifm_rd,
    output logic             line_clr,
    output logic [K-1:0]     psum_rd,
    output logic [K-1:0]     psum_wr,
    output logic             out_valid,
    output logic [CW-1:0]    cur_filter,
    output logic [CW-1:0]    cur_channel
);
    localparam int KK  = K * K;
    localparam int OUT = (IFM - K) / STRIDE + 1;
    localparam int OFM = (IFM - 1) * STRIDE + K - 2 * PAD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WGT,
        S_COMPUTE,
        S_LINE_GAP,
        S_NEXT_PASS,
        S_DONE
    } state_t;

    state_t        state;
    logic          mode;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] col_cnt;
    logic [CW-1:0] line_cnt;
    logic [CW-1:0] f_cnt;
    logic [CW-1:0] c_cnt;

    logic last_w, last_col, last_line, last_c, last_f;
    assign last_w    = (w_cnt    == CW'(KK - 1));
    assign last_col  = (col_cnt  == CW'(IFM - 1));
    assign last_line = (line_cnt == CW'(IFM - 1));
    assign last_c    = (c_cnt    == CW'(CI - 1));
    assign last_f    = (f_cnt    == CW'(CO - 1));

    // Pass sequencing FSM with its weight / column / line / channel / filter counters
    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= S_IDLE;
            mode     <= 1'b0;
            w_cnt    <= '0;
            col_cnt  <= '0;
            line_cnt <= '0;
            f_cnt    <= '0;
            c_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode  <= cfg_mode;
                        w_cnt <= '0;
                        state <= S_LOAD_WGT;
                    end
                end
                S_LOAD_WGT: begin
                    if (last_w) begin
                        w_cnt    <= '0;
                        col_cnt  <= '0;
                        line_cnt <= '0;
                        state    <= S_COMPUTE;
                    end else begin
                        w_cnt <= w_cnt + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    // a stalled cycle leaves every counter untouched
                    if (ready) begin
                        if (last_col) begin
                            state <= last_line ? S_NEXT_PASS : S_LINE_GAP;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                S_LINE_GAP: begin
                    line_cnt <= line_cnt + 1'b1;
                    col_cnt  <= '0;
                    state    <= S_COMPUTE;
                end
                S_NEXT_PASS: begin
                    w_cnt <= '0;
                    if (last_c) begin
                        c_cnt <= '0;
                        if (last_f) begin
                            // final pass: indices already read back as 0 during DONE
                            f_cnt <= '0;
                            state <= S_DONE;
                        end else begin
                            f_cnt <= f_cnt + 1'b1;
                            state <= S_LOAD_WGT;
                        end
                    end else begin
                        c_cnt <= c_cnt + 1'b1;
                        state <= S_LOAD_WGT;
                    end
                end
                S_DONE: begin
                    f_cnt <= '0;
                    c_cnt <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Convolution column window: I = K-1 + o*STRIDE for an output column o < OUT
    logic [CW-1:0] col_off;
    logic          conv_col;
    assign col_off  = col_cnt - CW'(K - 1);
    assign conv_col = (col_cnt >= CW'(K - 1)) &&
                      ((col_off % CW'(STRIDE)) == '0) &&
                      ((col_off / CW'(STRIDE)) <= CW'(OUT - 1));

    // Per kernel row: which lines feed a valid output row in each mode
    logic [K-1:0] conv_row;
    logic [K-1:0] tr_row;
    for (genvar gi = 0; gi < K; gi++) begin : g_row
        logic [CW-1:0]        l_off;
        logic signed [CW+1:0] y;
        assign l_off         = line_cnt - CW'(gi);
        assign conv_row[gi]  = (line_cnt >= CW'(gi)) &&
                               ((l_off % CW'(STRIDE)) == '0) &&
                               ((l_off / CW'(STRIDE)) <= CW'(OUT - 1));
        // transposed output row index L*STRIDE + i - PAD, kept signed so top padding goes negative
        assign y             = $signed({2'b00, line_cnt}) * $signed((CW+2)'(STRIDE)) +
                               $signed((CW+2)'(gi)) - $signed((CW+2)'(PAD));
        assign tr_row[gi]    = !y[CW+1] && (y <= $signed((CW+2)'(OFM - 1)));
    end

    logic         in_comp;
    logic [K-1:0] row_en;
    logic         col_en;
    assign in_comp = (state == S_COMPUTE) && ready;
    assign row_en  = mode ? tr_row : conv_row;
    assign col_en  = mode | conv_col;

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign wgt_rd      = (state == S_LOAD_WGT);
    assign wgt_sel     = wgt_rd ? (KK'(1) << w_cnt) : '0;
    assign ifm_rd      = in_comp;
    assign line_clr    = (state == S_LINE_GAP) || (state == S_NEXT_PASS);
    assign psum_wr     = (in_comp && col_en) ? row_en : '0;
    // first channel of a pass starts fresh partial sums, so nothing to read back
    assign psum_rd     = (c_cnt != '0) ? psum_wr : '0;
    assign out_valid   = psum_wr[K-1] && last_c;
    assign cur_filter  = f_cnt;
    assign cur_channel = c_cnt;
endmodule

// File: tb/tb_tconv_seq_ctrl.sv
// Bench for tconv_seq_ctrl: a lockstep reference walks the pass / line / column
// nesting directly and predicts every output each cycle, plus scenario tallies.
module tb_tconv_seq_ctrl;
    localparam int K = 4, IFM = 9, S = 2, PAD = 2, CI = 3, CO = 4, CW = 10;
    localparam int KK  = K * K;
    localparam int OUT = (IFM - K) / S + 1;
    localparam int OFM = (IFM - 1) * S + K - 2 * PAD;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          wgt_rd;
        logic [KK-1:0] wgt_sel;
        logic          ifm_rd;
        logic          line_clr;
        logic [K-1:0]  psum_rd;
        logic [K-1:0]  psum_wr;
        logic          out_valid;
        logic [CW-1:0] cur_filter;
        logic [CW-1:0] cur_channel;
    } obs_t;

    typedef struct {
        logic mode;
        int   stall;
        int   exp_len;
        int   exp_ov;
        int   exp_wgt;
        int   exp_pw0;
    } vec_t;

    logic clk1 = 1'b0, rst, start, cfg_mode, ready;
    logic busy, done, wgt_rd, ifm_rd, line_clr, out_valid;
    logic [KK-1:0] wgt_sel;
    logic [K-1:0]  psum_rd, psum_wr;
    logic [CW-1:0] cur_filter, cur_channel;
    obs_t obs;

    // small configuration instance
    logic start2;
    logic busy2, done2, wgt_rd2, ifm_rd2, line_clr2, out_valid2;
    logic [8:0] wgt_sel2;
    logic [2:0] psum_rd2, psum_wr2;
    logic [7:0] cur_filter2, cur_channel2;

    int tests = 0, fails = 0, cyc_cnt = 0, stall_pct = 0;
    int t0, done_at, n_ov, n_wgt, n_pw0, n_ss, n_stall;

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc_cnt <= cyc_cnt + 1;

    tconv_seq_ctrl #(.K(K), .IFM(IFM), .STRIDE(S), .PAD(PAD), .CI(CI), .CO(CO), .CW(CW)) dut (
        .clk1(clk1), .rst(rst), .start(start), .cfg_mode(cfg_mode), .ready(ready),
        .busy(busy), .done(done), .wgt_rd(wgt_rd), .wgt_sel(wgt_sel), .ifm_rd(ifm_rd),
        .line_clr(line_clr), .psum_rd(psum_rd), .psum_wr(psum_wr), .out_valid(out_valid),
        .cur_filter(cur_filter), .cur_channel(cur_channel));

    tconv_seq_ctrl #(.K(3), .IFM(5), .STRIDE(1), .PAD(1), .CI(1), .CO(1), .CW(8)) dut2 (
        .clk1(clk1), .rst(rst), .start(start2), .cfg_mode(1'b0), .ready(1'b1),
        .busy(busy2), .done(done2), .wgt_rd(wgt_rd2), .wgt_sel(wgt_sel2), .ifm_rd(ifm_rd2),
        .line_clr(line_clr2), .psum_rd(psum_rd2), .psum_wr(psum_wr2), .out_valid(out_valid2),
        .cur_filter(cur_filter2), .cur_channel(cur_channel2));

    assign obs = {busy, done, wgt_rd, wgt_sel, ifm_rd, line_clr, psum_rd, psum_wr,
                  out_valid, cur_filter, cur_channel};

    task automatic check_int(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic obs_t base(input int f, input int c);
        obs_t e;
        e = '0;
        e.busy        = 1'b1;
        e.cur_filter  = CW'(f);
        e.cur_channel = CW'(c);
        return e;
    endfunction

    // Expected COMPUTE outputs straight from the output-geometry rules
    function automatic obs_t exp_compute(input logic md, input int l, input int i,
                                         input int f, input int c, input logic rdy);
        obs_t e;
        logic col, row;
        int   y;
        e = base(f, c);
        if (!rdy) return e;
        e.ifm_rd = 1'b1;
        col = md;
        if (!md) for (int o = 0; o < OUT; o++) if (o * S + K - 1 == i) col = 1'b1;
        for (int r = 0; r < K; r++) begin
            row = 1'b0;
            if (md) begin
                y   = l * S + r - PAD;
                row = (y >= 0) && (y < OFM);
            end else begin
                for (int o = 0; o < OUT; o++) if (o * S + r == l) row = 1'b1;
            end
            e.psum_wr[r] = row && col;
            e.psum_rd[r] = row && col && (c != 0);
        end
        e.out_valid = e.psum_wr[K-1] && (c == CI - 1);
        return e;
    endfunction

    // Called at a negedge: compare, tally, then move to just after the next posedge
    task automatic cyc(input obs_t e, input string nm);
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, obs, e, $time);
        end
        if (obs.done && done_at < 0) done_at = cyc_cnt - t0;
        n_ov  += int'(obs.out_valid);
        n_wgt += int'(obs.wgt_rd);
        n_pw0 += int'(obs.psum_wr[0]);
        @(posedge clk1);
        #1;
        ready = (int'($urandom_range(99)) >= stall_pct);
    endtask

    // One full run starting in an IDLE cycle; returns just after DONE
    task automatic run(input logic md, input int sp, input bit hold, input bit tog);
        obs_t e;
        logic rdy;
        stall_pct = sp;
        done_at = -1; n_ov = 0; n_wgt = 0; n_pw0 = 0; n_ss = 0; n_stall = 0;
        start = 1'b1; cfg_mode = md; t0 = cyc_cnt;
        @(negedge clk1);
        cyc('0, "idle_at_start");
        if (!hold) start = 1'b0;
        for (int f = 0; f < CO; f++) begin
            for (int c = 0; c < CI; c++) begin
                for (int w = 0; w < KK; w++) begin
                    @(negedge clk1);
                    e = base(f, c);
                    e.wgt_rd  = 1'b1;
                    e.wgt_sel = KK'(1) << w;
                    cyc(e, "load_wgt");
                    if (tog && f == 0 && c == 0 && w == 0) cfg_mode = !md;
                end
                for (int l = 0; l < IFM; l++) begin
                    for (int i = 0; i < IFM; i++) begin
                        rdy = 1'b0;
                        while (!rdy) begin
                            @(negedge clk1);
                            rdy = ready;
                            if (!rdy) begin
                                n_stall++;
                                if (obs.ifm_rd || (|obs.psum_wr) || (|obs.psum_rd) || obs.out_valid)
                                    n_ss++;
                            end
                            cyc(exp_compute(md, l, i, f, c, rdy), "compute");
                        end
                    end
                    if (l < IFM - 1) begin
                        @(negedge clk1);
                        e = base(f, c);
                        e.line_clr = 1'b1;
                        cyc(e, "line_gap");
                    end
                end
                @(negedge clk1);
                e = base(f, c);
                e.line_clr = 1'b1;
                cyc(e, "next_pass");
            end
        end
        @(negedge clk1);
        e = base(0, 0);
        e.done = 1'b1;
        cyc(e, "done");
    endtask

    vec_t tab[4];
    int d2, ov2, prd2, wgt2, pw2;

    initial begin
        tab[0] = '{mode: 1'b0, stall: 0,  exp_len: 1273, exp_ov: 36,  exp_wgt: 192, exp_pw0: 108};
        tab[1] = '{mode: 1'b1, stall: 0,  exp_len: 1273, exp_ov: 288, exp_wgt: 192, exp_pw0: 864};
        tab[2] = '{mode: 1'b0, stall: 30, exp_len: 1273, exp_ov: 36,  exp_wgt: 192, exp_pw0: 108};
        tab[3] = '{mode: 1'b1, stall: 30, exp_len: 1273, exp_ov: 288, exp_wgt: 192, exp_pw0: 864};

        rst = 1'b1; start = 1'b0; cfg_mode = 1'b0; ready = 1'b1; start2 = 1'b0;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL reset_state: got %h expected 0", obs);
        end
        tests++;
        if ({busy2, done2, wgt_rd2, wgt_sel2, ifm_rd2, line_clr2, psum_rd2, psum_wr2,
             out_valid2, cur_filter2, cur_channel2} !== '0) begin
            fails++;
            $display("FAIL reset_state_small: some output nonzero");
        end
        @(posedge clk1);
        #1 rst = 1'b0;

        // scenario table: mode and stall rate against run length and strobe tallies
        for (int v = 0; v < 4; v++) begin
            run(tab[v].mode, tab[v].stall, 1'b0, 1'b0);
            check_int($sformatf("done_latency[%0d]", v), done_at, tab[v].exp_len + n_stall);
            check_int($sformatf("out_valid_cnt[%0d]", v), n_ov, tab[v].exp_ov);
            check_int($sformatf("wgt_rd_cnt[%0d]", v), n_wgt, tab[v].exp_wgt);
            check_int($sformatf("psum_wr0_cnt[%0d]", v), n_pw0, tab[v].exp_pw0);
            check_int($sformatf("stall_strobes[%0d]", v), n_ss, 0);
        end

        // reset in pass 5 (f=1, c=1), line 2, column 4 = cycle t0+465
        stall_pct = 0; ready = 1'b1;
        done_at = -1; start = 1'b1; cfg_mode = 1'b0; t0 = cyc_cnt;
        @(posedge clk1);
        #1 start = 1'b0;
        repeat (464) @(posedge clk1);
        #1 rst = 1'b1;
        @(negedge clk1);
        cyc(exp_compute(1'b0, 2, 4, 1, 1, 1'b1), "mid_pass_before_rst");
        rst = 1'b0;
        @(negedge clk1);
        cyc('0, "after_rst");
        @(negedge clk1);
        cyc('0, "idle_no_start");
        run(1'b0, 0, 1'b0, 1'b0);
        check_int("post_rst_latency", done_at, 1273);
        check_int("post_rst_out_valid", n_ov, 36);

        // start held high: back-to-back runs, mid-run cfg_mode flips ignored
        run(1'b0, 0, 1'b1, 1'b1);
        check_int("b2b_latency0", done_at, 1273);
        check_int("b2b_out_valid0", n_ov, 36);
        run(1'b1, 20, 1'b1, 1'b1);
        start = 1'b0;
        check_int("b2b_latency1", done_at, 1273 + n_stall);
        check_int("b2b_out_valid1", n_ov, 288);
        @(negedge clk1);
        cyc('0, "idle_after_b2b");

        // small configuration: K=3, IFM=5, STRIDE=1, single pass
        d2 = -1; ov2 = 0; prd2 = 0; wgt2 = 0; pw2 = 0;
        start2 = 1'b1; t0 = cyc_cnt;
        @(posedge clk1);
        #1 start2 = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk1);
            if (done2 && d2 < 0) d2 = cyc_cnt - t0;
            ov2  += int'(out_valid2);
            prd2 += $countones(psum_rd2);
            wgt2 += int'(wgt_rd2);
            pw2  += $countones(psum_wr2);
            @(posedge clk1);
            #1;
        end
        check_int("small_done_latency", d2, 40);
        check_int("small_out_valid", ov2, 9);
        check_int("small_psum_rd", prd2, 0);
        check_int("small_wgt_rd", wgt2, 9);
        check_int("small_psum_wr_bits", pw2, 27);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
